// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Purpose
//   Shared types and helpers for the write side of the async FIFO subsystem.
//   The write arbiter and the round-robin picker import this package so that
//   the state encoding and the index-width rule stay identical everywhere.
//
// Contents
//   FIFO_DATA_WIDTH  default word width, matching the async FIFO default
//   arb_state_t      arbiter state encoding (IDLE, BURST)
//   idx_width()      bits needed to hold an index 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Default word width of one FIFO entry.
  localparam int FIFO_DATA_WIDTH = 8;

  // IDLE: no owner, arbitration happens here.
  // BURST: one producer owns the write port.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of an index into a vector of n entries. A single-entry vector
  // still gets a 1-bit index so that ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Purpose
//   Purely combinational round-robin picker. Starting one position after the
//   pointer and wrapping around, it returns the first index whose request bit
//   is set. The pointer itself is checked last, so the previous winner has
//   the lowest priority on the next pick.
//   Kept generic so the read-side scheduler can reuse it unchanged.
//
// Ports
//   req      in   NUM_REQ   request vector, one bit per requester
//   ptr      in   PW        index of the previous winner
//   winner   out  PW        chosen index (0 when nothing is requesting)
//   any_req  out  1         at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      winner,
  output logic               any_req
);

  // Candidate index at a given distance past the pointer, wrapped into
  // the range 0..NUM_REQ-1. Works for non-power-of-two requester counts.
  function automatic logic [PW-1:0] cand(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % NUM_REQ);
  endfunction

  // The scan runs from the farthest candidate back to the nearest one, so
  // the last matching assignment is the nearest requester after the pointer.
  // This avoids a "found" flag and gives a clean priority chain.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[cand(ptr, off)]) begin
        winner = cand(ptr, off);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Purpose
//   Shares the single write port of the async FIFO between NUM_REQ producers
//   living in the write clock domain. Ownership of the port is granted as a
//   burst, round-robin between producers. While a producer owns the port its
//   words go straight to the FIFO in the same cycle they are presented,
//   unless the FIFO reports full. A burst ends on the last word of a packet,
//   after MAX_BURST words, or after IDLE_TIMEOUT consecutive cycles in which
//   the owner presents nothing. A cut packet simply continues on that
//   producer's next grant.
//
// Ports
//   clk         in   1                    write-domain clock
//   rst         in   1                    asynchronous, active-high reset
//   req         in   NUM_REQ              producer i presents a valid word
//   req_data    in   NUM_REQ*DATA_WIDTH   word of producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    in   NUM_REQ              word of producer i ends its packet
//   ack         out  NUM_REQ              one-hot, word of producer i taken this cycle
//   fifo_full   in   1                    FIFO full, write-domain version
//   fifo_write  out  1                    FIFO write strobe
//   fifo_data   out  DATA_WIDTH           FIFO write data, zero when not writing
//   grant_id    out  GW                   current or most recent owner
//   busy        out  1                    a burst is in progress
//
// Notes
//   The write path is combinational from req/fifo_full to fifo_write/ack, so
//   fifo_full has to be the synchronous write-side flag of the FIFO.
// -----------------------------------------------------------------------------
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH   = FIFO_DATA_WIDTH,
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_BURST    = 4,
  parameter  int IDLE_TIMEOUT = 8,
  localparam int GW           = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  // Counter widths are just large enough to hold their terminal value.
  // Both counters are cleared on every exit, so neither ever wraps.
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t      state_q;
  logic [GW-1:0]   owner_q;
  logic [GW-1:0]   ptr_q;
  logic [BW-1:0]   beat_q;
  logic [IW-1:0]   idle_q;

  logic [GW-1:0]         pick_winner;
  logic                  pick_any;
  logic                  in_burst;
  logic                  owner_req;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  xfer;
  logic                  beat_at_max;
  logic                  idle_at_limit;
  logic                  burst_done;
  logic                  timed_out;
  logic                  burst_exit;

  // The picker only matters in IDLE; its result is ignored during a burst,
  // which is what makes non-owner requests invisible while a grant is held.
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  // Select the owner's request, last flag and word. A word only moves when
  // the owner has one and the FIFO has room; a full FIFO stalls the burst
  // without counting as owner idleness.
  // The exit conditions are evaluated on the current counter values so the
  // decision lands on the same edge as the word that triggers it. The
  // last-word and max-burst cases share one exit term, so a word that is
  // both still causes only one rotation.
  always_comb begin
    in_burst      = (state_q == BURST);
    owner_req     = req[owner_q];
    owner_last    = req_last[owner_q];
    owner_data    = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    xfer          = in_burst & owner_req & ~fifo_full;
    beat_at_max   = (beat_q == BW'(MAX_BURST - 1));
    idle_at_limit = (idle_q == IW'(IDLE_TIMEOUT - 1));
    burst_done    = xfer & (owner_last | beat_at_max);
    timed_out     = in_burst & ~owner_req & idle_at_limit;
    burst_exit    = burst_done | timed_out;
  end

  // Main arbiter state. Reset parks the pointer at the highest index so the
  // first scan after reset starts at producer 0.
  // IDLE registers the picked producer as owner, which costs one bubble
  // cycle between bursts. BURST counts delivered words and idle cycles and
  // on exit hands priority past the outgoing owner by moving the pointer
  // onto it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_winner;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (burst_exit) begin
            state_q <= IDLE;
            ptr_q   <= owner_q;
            beat_q  <= '0;
            idle_q  <= '0;
          end else if (xfer) begin
            beat_q  <= beat_q + 1'b1;
            idle_q  <= '0;
          end else if (!owner_req) begin
            idle_q  <= idle_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FIFO-side outputs and the one-hot acknowledge follow xfer directly, so
  // the producer sees its word accepted in the very cycle it is written.
  // Data is forced to zero whenever no write happens to keep the bus quiet.
  always_comb begin
    ack          = '0;
    ack[owner_q] = xfer;
    fifo_write   = xfer;
    fifo_data    = xfer ? owner_data : '0;
  end

  // Status outputs come straight from registers.
  always_comb begin
    grant_id = owner_q;
    busy     = in_burst;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Purpose
//   Self-checking bench for fifo_write_arbiter with four producers,
//   MAX_BURST=4, IDLE_TIMEOUT=8 and 8-bit words. Each producer is a small
//   word source; every word the arbiter is expected to write is pushed to a
//   scoreboard queue when the stimulus is set up, and popped and compared
//   whenever the DUT writes.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int IT    = 8;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     ack;
  logic              fifo_full;
  logic              fifo_write;
  logic [DW-1:0]     fifo_data;
  logic [1:0]        grant_id;
  logic              busy;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_data [NR][DEPTH];
  logic          src_last [NR][DEPTH];
  int            src_len  [NR];
  int            src_pos  [NR];
  logic          src_en   [NR];
  logic [NR-1:0] ack_seen;
  int            tests_run    = 0;
  int            tests_failed = 0;
  int            write_count  = 0;

  fifo_write_arbiter #(
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // Free-running write clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present the head word of every enabled producer that still has words.
  task automatic driveInputs();
    for (int i = 0; i < NR; i++) begin
      int  p;
      logic avail;
      avail = src_en[i] && (src_pos[i] < src_len[i]);
      p     = (src_pos[i] < DEPTH) ? src_pos[i] : 0;
      req[i]              = avail;
      req_data[i*DW +: DW] = avail ? src_data[i][p] : '0;
      req_last[i]         = avail & src_last[i][p];
    end
  endtask

  // Fill producer i with len words base, base+1, ...; last_idx<0 means no last.
  task automatic loadSource(input int i, input int len, input logic [DW-1:0] base,
                            input int last_idx);
    for (int k = 0; k < DEPTH; k++) begin
      src_data[i][k] = base + DW'(k);
      src_last[i][k] = (k == last_idx);
    end
    src_len[i] = len;
    src_pos[i] = 0;
    src_en[i]  = 1'b1;
  endtask

  // Queue the words k_from..k_to of producer id, base+k each.
  task automatic pushExpected(input int id, input logic [DW-1:0] base,
                              input int k_from, input int k_to);
    for (int k = k_from; k <= k_to; k++) begin
      exp_t e;
      e.id   = 2'(id);
      e.data = base + DW'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic disableSources();
    for (int i = 0; i < NR; i++) src_en[i] = 1'b0;
    driveInputs();
  endtask

  // Mid-cycle monitor: compares every write against the scoreboard and
  // checks that the port is quiet when nothing is written.
  task automatic sampleCycle();
    @(negedge clk);
    ack_seen = ack;
    if (fifo_write) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'(fifo_data), 32'hFFFF_FFFF);
      end else begin
        exp_t          e;
        logic [NR-1:0] exp_ack;
        e       = exp_q.pop_front();
        exp_ack = 4'b0001 << e.id;
        checkOutput("wr_data", 32'(fifo_data), 32'(e.data));
        checkOutput("wr_ack", 32'(ack), 32'(exp_ack));
        checkOutput("wr_gid", 32'(grant_id), 32'(e.id));
      end
    end else begin
      checkOutput("ack_idle", 32'(ack), 32'h0);
      checkOutput("data_idle", 32'(fifo_data), 32'h0);
    end
  endtask

  // Just after the clock edge: retire accepted words and drive the next ones.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_seen[i]) src_pos[i]++;
    end
    driveInputs();
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      sampleCycle();
      applyStimulus();
    end
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    fifo_full = 1'b0;
    ack_seen  = '0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      src_en[i]  = 1'b0;
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    driveInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wc0;
    rst       = 1'b1;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;
    req_last  = '0;
    ack_seen  = '0;
    for (int i = 0; i < NR; i++) begin
      src_en[i]  = 1'b0;
      src_len[i] = 0;
      src_pos[i] = 0;
      for (int k = 0; k < DEPTH; k++) begin
        src_data[i][k] = '0;
        src_last[i][k] = 1'b0;
      end
    end

    // Reset state while reset is held.
    #1;
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_write", 32'(fifo_write), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_gid", 32'(grant_id), 32'h0);
    checkOutput("rst_data", 32'(fifo_data), 32'h0);
    resetDut();

    // Single producer 2, three-word packet ending on 0xA3.
    loadSource(2, 3, 8'hA1, 2);
    pushExpected(2, 8'hA1, 0, 2);
    driveInputs();
    sampleCycle();
    checkOutput("t2_bubble_busy", 32'(busy), 32'h0);
    applyStimulus();
    sampleCycle();
    checkOutput("t2_busy", 32'(busy), 32'h1);
    checkOutput("t2_gid", 32'(grant_id), 32'h2);
    applyStimulus();
    runCycles(2);
    sampleCycle();
    checkOutput("t2_idle_after_last", 32'(busy), 32'h0);
    applyStimulus();
    runCycles(2);
    checkOutput("t2_sb_empty", 32'(exp_q.size()), 32'h0);

    // All producers requesting, no packet ends: 0,1,2,3,0 with 4 words each.
    resetDut();
    for (int i = 0; i < NR; i++) loadSource(i, DEPTH, 8'(i * 8'h40), -1);
    pushExpected(0, 8'h00, 0, 3);
    pushExpected(1, 8'h40, 0, 3);
    pushExpected(2, 8'h80, 0, 3);
    pushExpected(3, 8'hC0, 0, 3);
    pushExpected(0, 8'h00, 4, 7);
    driveInputs();
    wc0 = write_count;
    runCycles(25);
    disableSources();
    checkOutput("t3_writes", 32'(write_count - wc0), 32'd20);
    runCycles(3);
    checkOutput("t3_sb_empty", 32'(exp_q.size()), 32'h0);

    // FIFO full for three cycles after the second word of a burst.
    resetDut();
    loadSource(0, 8, 8'h40, -1);
    loadSource(1, 8, 8'h80, -1);
    pushExpected(0, 8'h40, 0, 3);
    pushExpected(1, 8'h80, 0, 0);
    driveInputs();
    runCycles(2);
    sampleCycle();
    applyStimulus();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sampleCycle();
      checkOutput("t4_full_write", 32'(fifo_write), 32'h0);
      checkOutput("t4_full_ack", 32'(ack), 32'h0);
      checkOutput("t4_full_busy", 32'(busy), 32'h1);
      applyStimulus();
    end
    fifo_full = 1'b0;
    runCycles(2);
    sampleCycle();
    checkOutput("t4_rotate_bubble", 32'(busy), 32'h0);
    applyStimulus();
    sampleCycle();
    checkOutput("t4_next_gid", 32'(grant_id), 32'h1);
    applyStimulus();
    disableSources();
    runCycles(2);
    checkOutput("t4_sb_empty", 32'(exp_q.size()), 32'h0);

    // Owner 0 stops after one word while producer 3 waits: timeout release.
    resetDut();
    loadSource(0, 1, 8'h50, -1);
    loadSource(3, 16, 8'hC0, -1);
    pushExpected(0, 8'h50, 0, 0);
    pushExpected(3, 8'hC0, 0, 0);
    driveInputs();
    runCycles(2);
    for (int c = 0; c < IT; c++) begin
      sampleCycle();
      checkOutput("t5_hold_busy", 32'(busy), 32'h1);
      checkOutput("t5_ack3_ignored", 32'(ack[3]), 32'h0);
      applyStimulus();
    end
    sampleCycle();
    checkOutput("t5_released", 32'(busy), 32'h0);
    applyStimulus();
    sampleCycle();
    checkOutput("t5_next_gid", 32'(grant_id), 32'h3);
    applyStimulus();

    // Reset asserted while producer 3 is streaming: outputs clear at once.
    checkOutput("t1_pre_write", 32'(fifo_write), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t1_ack", 32'(ack), 32'h0);
    checkOutput("t1_write", 32'(fifo_write), 32'h0);
    checkOutput("t1_busy", 32'(busy), 32'h0);
    checkOutput("t1_gid", 32'(grant_id), 32'h0);
    resetDut();

    // Reset during a burst owned by producer 1, all requesting.
    for (int i = 0; i < NR; i++) loadSource(i, 16, 8'(i * 8'h40 + 8'h10), -1);
    pushExpected(0, 8'h10, 0, 3);
    pushExpected(1, 8'h50, 0, 0);
    driveInputs();
    runCycles(7);
    checkOutput("t6_pre_gid", 32'(grant_id), 32'h1);
    checkOutput("t6_pre_write", 32'(fifo_write), 32'h1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    ack_seen = '0;
    for (int i = 0; i < NR; i++) loadSource(i, 16, 8'(i * 8'h40 + 8'h10), -1);
    pushExpected(0, 8'h10, 0, 0);
    driveInputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sampleCycle();
    checkOutput("t6_bubble", 32'(busy), 32'h0);
    applyStimulus();
    sampleCycle();
    checkOutput("t6_first_gid", 32'(grant_id), 32'h0);
    applyStimulus();
    disableSources();
    runCycles(2);
    checkOutput("t6_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
